inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 91 +++++++++
 tb/tb_inst_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - circular instruction queue between fetch and decode
// Registered issue port; no bypass, so a pushed entry issues one edge later at the earliest.
module inst_queue #(
  parameter int IQ_DEPTH       = 16,
  parameter int IQ_FULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        IF_input_valid,
  input  logic [31:0] IF_inst,
  input  logic [31:0] IF_inst_pc,
  input  logic        IF_predicted_to_jump,
  input  logic [31:0] IF_predicted_pc,
  output logic        IF_IQ_is_full,
  input  logic        ROB_is_full,
  input  logic        RS_is_full,
  input  logic        LSB_is_full,
  input  logic        roll_back_flag,
  output logic        ID_output_valid,
  output logic [31:0] ID_inst,
  output logic [31:0] ID_inst_pc,
  output logic        ID_predicted_to_jump,
  output logic [31:0] ID_predicted_pc
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 97;

  logic [ENT_W-1:0] mem [IQ_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [ENT_W-1:0] head_ent;
  logic             stall;
  logic             do_push;
  logic             do_pop;

  assign stall    = ROB_is_full | RS_is_full | LSB_is_full;
  assign do_push  = rdy && !roll_back_flag && IF_input_valid && (count < CNT_W'(IQ_DEPTH));
  assign do_pop   = rdy && !roll_back_flag && (count != '0) && !stall;
  assign head_ent = mem[head];

  // Fetch keeps a few slots of slack for requests already on their way.
  assign IF_IQ_is_full = (count >= CNT_W'(IQ_DEPTH - IQ_FULL_MARGIN));

  // Entry storage carries no reset; only the control state below does.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[tail] <= {IF_inst, IF_inst_pc, IF_predicted_to_jump, IF_predicted_pc};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head                 <= '0;
      tail                 <= '0;
      count                <= '0;
      ID_output_valid      <= 1'b0;
      ID_inst              <= '0;
      ID_inst_pc           <= '0;
      ID_predicted_to_jump <= 1'b0;
      ID_predicted_pc      <= '0;
    end else begin
      ID_output_valid <= do_pop;
      if (rdy && roll_back_flag) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_push) begin
          tail <= tail + PTR_W'(1);
        end
        if (do_pop) begin
          head                 <= head + PTR_W'(1);
          ID_inst              <= head_ent[96:65];
          ID_inst_pc           <= head_ent[64:33];
          ID_predicted_to_jump <= head_ent[32];
          ID_predicted_pc      <= head_ent[31:0];
        end
        case ({do_push, do_pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - scoreboard bench for inst_queue
// Stimulus pushes expected entries; a negedge monitor pops and compares each issue.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        IF_input_valid;
  logic [31:0] IF_inst;
  logic [31:0] IF_inst_pc;
  logic        IF_predicted_to_jump;
  logic [31:0] IF_predicted_pc;
  logic        IF_IQ_is_full;
  logic        ROB_is_full;
  logic        RS_is_full;
  logic        LSB_is_full;
  logic        roll_back_flag;
  logic        ID_output_valid;
  logic [31:0] ID_inst;
  logic [31:0] ID_inst_pc;
  logic        ID_predicted_to_jump;
  logic [31:0] ID_predicted_pc;

  int n_vec  = 0;
  int n_miss = 0;
  logic [96:0] sb [$];

  inst_queue #(.IQ_DEPTH(16), .IQ_FULL_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .IF_input_valid(IF_input_valid), .IF_inst(IF_inst), .IF_inst_pc(IF_inst_pc),
    .IF_predicted_to_jump(IF_predicted_to_jump), .IF_predicted_pc(IF_predicted_pc),
    .IF_IQ_is_full(IF_IQ_is_full), .ROB_is_full(ROB_is_full), .RS_is_full(RS_is_full),
    .LSB_is_full(LSB_is_full), .roll_back_flag(roll_back_flag),
    .ID_output_valid(ID_output_valid), .ID_inst(ID_inst), .ID_inst_pc(ID_inst_pc),
    .ID_predicted_to_jump(ID_predicted_to_jump), .ID_predicted_pc(ID_predicted_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [96:0] mk(input logic [31:0] pc);
    return {pc ^ 32'h1357_9BDF, pc, pc[2], pc + 32'd8};
  endfunction

  always @(negedge clk) begin
    if (ID_output_valid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL issue_unexpected: got pc=%h, required no issue", ID_inst_pc);
      end else begin
        logic [96:0] exp_e;
        exp_e = sb.pop_front();
        if ({ID_inst, ID_inst_pc, ID_predicted_to_jump, ID_predicted_pc} !== exp_e) begin
          n_miss++;
          $display("FAIL issue_data: got %h, required %h",
                   {ID_inst, ID_inst_pc, ID_predicted_to_jump, ID_predicted_pc}, exp_e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input bit expect_accept);
    logic [96:0] e;
    e = mk(pc);
    IF_input_valid       = 1'b1;
    IF_inst              = e[96:65];
    IF_inst_pc           = e[64:33];
    IF_predicted_to_jump = e[32];
    IF_predicted_pc      = e[31:0];
    if (expect_accept) sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_m;
    int pushed;
    int guard;
    bit st;
    bit p;

    rst = 1'b1; rdy = 1'b1; IF_input_valid = 1'b0; IF_inst = '0; IF_inst_pc = '0;
    IF_predicted_to_jump = 1'b0; IF_predicted_pc = '0;
    ROB_is_full = 1'b0; RS_is_full = 1'b0; LSB_is_full = 1'b0; roll_back_flag = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(ID_output_valid), 0);
    chk("rst_inst", ID_inst, 0);
    chk("rst_pc", ID_inst_pc, 0);
    chk("rst_pj", 32'(ID_predicted_to_jump), 0);
    chk("rst_ppc", ID_predicted_pc, 0);
    chk("rst_full", 32'(IF_IQ_is_full), 0);
    rst = 1'b0;

    // basic order and 2-cycle latency
    drive(32'h0, 1); tick();
    chk("basic_no_bypass", 32'(ID_output_valid), 0);
    drive(32'h4, 1); tick();
    chk("basic_issue1", 32'(ID_output_valid), 1);
    drive(32'h8, 1); tick();
    chk("basic_issue2", 32'(ID_output_valid), 1);
    IF_input_valid = 1'b0; tick();
    chk("basic_issue3", 32'(ID_output_valid), 1);
    tick();
    chk("basic_idle", 32'(ID_output_valid), 0);
    drain(5);

    // fill under ROB stall, 17th push dropped
    ROB_is_full = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drive(32'h100 + 32'(4 * k), 1); tick();
      chk($sformatf("fill_full_%0d", k + 1), 32'(IF_IQ_is_full), 32'((k + 1) >= 14));
    end
    drive(32'hDEAD_0000, 0); tick();
    chk("fill_17th_full", 32'(IF_IQ_is_full), 1);
    chk("fill_stall_no_issue", 32'(ID_output_valid), 0);
    IF_input_valid = 1'b0; ROB_is_full = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      tick();
      chk($sformatf("empty_full_%0d", j), 32'(IF_IQ_is_full), 32'((16 - j) >= 14));
    end
    tick();
    chk("fill_after_16", 32'(ID_output_valid), 0);
    drain(5);

    // wrap-around with random stall
    cnt_m = 0; pushed = 0; guard = 0;
    while ((pushed < 40 || cnt_m != 0) && guard < 600) begin
      st = ($urandom_range(0, 3) == 0);
      p  = (pushed < 40) && (cnt_m < 16) && ($urandom_range(0, 3) != 0);
      RS_is_full = st;
      if (p) begin
        drive(32'h1000 + 32'(4 * pushed), 1);
        pushed++;
      end else begin
        IF_input_valid = 1'b0;
      end
      tick();
      cnt_m = cnt_m + int'(p) - ((cnt_m != 0 && !st) ? 1 : 0);
      guard++;
    end
    IF_input_valid = 1'b0; RS_is_full = 1'b0;
    drain(20);

    // stall release coinciding with a push keeps count at 5
    LSB_is_full = 1'b1;
    for (int k = 0; k < 5; k++) begin drive(32'h2000 + 32'(4 * k), 1); tick(); end
    LSB_is_full = 1'b0;
    drive(32'h2014, 1); tick();
    chk("simul_issue", 32'(ID_output_valid), 1);
    LSB_is_full = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      drive(32'h2100 + 32'(4 * i), 1); tick();
      chk($sformatf("simul_full_%0d", 5 + i), 32'(IF_IQ_is_full), 32'((5 + i) >= 14));
    end
    IF_input_valid = 1'b0; LSB_is_full = 1'b0;
    drain(20);

    // roll back with a concurrent push
    ROB_is_full = 1'b1;
    for (int k = 0; k < 7; k++) begin drive(32'h3000 + 32'(4 * k), 1); tick(); end
    ROB_is_full = 1'b0; roll_back_flag = 1'b1;
    drive(32'hBAD0_0000, 0); tick();
    chk("rb_valid", 32'(ID_output_valid), 0);
    sb.delete();
    roll_back_flag = 1'b0; IF_input_valid = 1'b0; tick();
    chk("rb_empty", 32'(ID_output_valid), 0);
    chk("rb_full", 32'(IF_IQ_is_full), 0);
    drive(32'h3400, 1); tick();
    chk("rb_push_lat1", 32'(ID_output_valid), 0);
    IF_input_valid = 1'b0; tick();
    chk("rb_push_lat2", 32'(ID_output_valid), 1);
    tick();
    chk("rb_after", 32'(ID_output_valid), 0);
    drain(5);

    // rdy low holds state; reset wins over rdy=0
    ROB_is_full = 1'b1;
    for (int k = 0; k < 4; k++) begin drive(32'h4000 + 32'(4 * k), 1); tick(); end
    ROB_is_full = 1'b0; rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(32'hDEAD_1000, 0); tick();
      chk($sformatf("rdy_low_%0d", k), 32'(ID_output_valid), 0);
    end
    IF_input_valid = 1'b0; rdy = 1'b1; tick();
    chk("rdy_resume", 32'(ID_output_valid), 1);
    #5;
    rst = 1'b1; rdy = 1'b0; drive(32'hDEAD_2000, 0); tick();
    sb.delete();
    chk("rst2_valid", 32'(ID_output_valid), 0);
    chk("rst2_inst", ID_inst, 0);
    chk("rst2_pc", ID_inst_pc, 0);
    chk("rst2_pj", 32'(ID_predicted_to_jump), 0);
    chk("rst2_ppc", ID_predicted_pc, 0);
    chk("rst2_full", 32'(IF_IQ_is_full), 0);
    rst = 1'b0; rdy = 1'b1; IF_input_valid = 1'b0;
    tick(); tick();
    chk("rst2_empty", 32'(ID_output_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
